// File: rtl/filter_bias_buffer_if.sv
// filter_bias_buffer_if: DMA write handshake and engine read bus of filter_bias_buffer.
// FB_RANGE_CHECK_EN adds the sticky wr_err output.
interface filter_bias_buffer_if #(
    parameter int NUM_FILTERS = 16,
    parameter int NUM_BIAS    = 120
);
    logic                           FB_write;
    logic                           FB_bias_or_filter;
    logic [15:0]                    FB_index_filter;
    logic [0:4][0:4][15:0]          FB_filter;
    logic [0:NUM_BIAS-1][15:0]      FB_bias;
    logic                           FB_finish;
    logic                           rd_en;
    logic [15:0]                    rd_filter_index;
    logic [15:0]                    rd_bias_index;
    logic [0:4][0:4][15:0]          rd_filter;
    logic [15:0]                    rd_bias;
    logic                           rd_valid;
    logic [NUM_FILTERS-1:0]         filters_loaded;
`ifdef FB_RANGE_CHECK_EN
    logic                           wr_err;
`endif

    modport master (
`ifdef FB_RANGE_CHECK_EN
        input  wr_err,
`endif
        output FB_write, FB_bias_or_filter, FB_index_filter, FB_filter, FB_bias,
        output rd_en, rd_filter_index, rd_bias_index,
        input  FB_finish, rd_filter, rd_bias, rd_valid, filters_loaded
    );

    modport slave (
`ifdef FB_RANGE_CHECK_EN
        output wr_err,
`endif
        input  FB_write, FB_bias_or_filter, FB_index_filter, FB_filter, FB_bias,
        input  rd_en, rd_filter_index, rd_bias_index,
        output FB_finish, rd_filter, rd_bias, rd_valid, filters_loaded
    );
endinterface

// File: rtl/filter_bias_buffer.sv
// filter_bias_buffer: 5x5 filter slots and bias vector, 4-phase DMA write, 1-cycle read.
// FB_RANGE_CHECK_EN: out-of-range filter writes are dropped and flag wr_err instead of wrapping.
module filter_bias_buffer #(
    parameter int NUM_FILTERS = 16,
    parameter int NUM_BIAS    = 120
) (
    input logic              clk,
    input logic              reset,
    filter_bias_buffer_if.slave b
);
    typedef enum logic {IDLE, ACK} state_t;
    typedef logic [0:4][0:4][15:0] filt_t;

    state_t                    state;
    filt_t                     filt_mem [NUM_FILTERS];
    logic [0:NUM_BIAS-1][15:0] bias_mem;
    logic [15:0]               widx;
    filt_t                     rfil;
    logic [15:0]               rbias;

`ifdef FB_RANGE_CHECK_EN
    assign widx = b.FB_index_filter;
`else
    assign widx = 16'(int'(b.FB_index_filter) % NUM_FILTERS);
`endif

    // Out-of-range read indices match no entry and therefore return zero.
    always_comb begin
        rfil  = '0;
        rbias = '0;
        for (int f = 0; f < NUM_FILTERS; f++)
            rfil = (b.rd_filter_index == 16'(f)) ? filt_mem[f] : rfil;
        for (int k = 0; k < NUM_BIAS; k++)
            rbias = (b.rd_bias_index == 16'(k)) ? bias_mem[k] : rbias;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            b.FB_finish      <= 1'b0;
            b.rd_valid       <= 1'b0;
            b.rd_filter      <= '0;
            b.rd_bias        <= '0;
            b.filters_loaded <= '0;
            filt_mem         <= '{default: '0};
            bias_mem         <= '0;
`ifdef FB_RANGE_CHECK_EN
            b.wr_err         <= 1'b0;
`endif
        end else begin
            b.rd_valid <= b.rd_en;
            if (b.rd_en) begin
                b.rd_filter <= rfil;
                b.rd_bias   <= rbias;
            end
            if (state == IDLE && b.FB_write) begin
                state       <= ACK;
                b.FB_finish <= 1'b1;
                if (b.FB_bias_or_filter) begin
                    for (int f = 0; f < NUM_FILTERS; f++)
                        if (widx == 16'(f)) begin
                            filt_mem[f]         <= b.FB_filter;
                            b.filters_loaded[f] <= 1'b1;
                        end
`ifdef FB_RANGE_CHECK_EN
                    if (b.FB_index_filter >= 16'(NUM_FILTERS))
                        b.wr_err <= 1'b1;
`endif
                end else begin
                    bias_mem <= b.FB_bias;
                end
            end else if (state == ACK && !b.FB_write) begin
                state       <= IDLE;
                b.FB_finish <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_filter_bias_buffer.sv
// tb_filter_bias_buffer: directed checks of write handshake, reads, reset and index range handling.
module tb_filter_bias_buffer;
    typedef logic [0:4][0:4][15:0] filt_t;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    int    n_vec = 0;
    int    n_bad = 0;
    filt_t ramp;

    always #5 clk = ~clk;

    filter_bias_buffer_if #(.NUM_FILTERS(16), .NUM_BIAS(120)) bus ();
    filter_bias_buffer #(.NUM_FILTERS(16), .NUM_BIAS(120)) dut (.clk(clk), .reset(reset), .b(bus));

    task automatic chk(input string tag, input logic [399:0] got, input logic [399:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic filt_t fill(input logic [15:0] v);
        filt_t r;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                r[i][j] = v;
        return r;
    endfunction

    task automatic wr(input logic bof, input logic [15:0] idx);
        bus.FB_bias_or_filter = bof;
        bus.FB_index_filter   = idx;
        bus.FB_write          = 1'b1;
        for (int n = 0; n < 20 && !bus.FB_finish; n++) tick();
        chk("wr_ack", bus.FB_finish, 1);
        bus.FB_write = 1'b0;
        for (int n = 0; n < 20 && bus.FB_finish; n++) tick();
        chk("wr_rel", bus.FB_finish, 0);
    endtask

    task automatic rd(input logic [15:0] fi, input logic [15:0] bi);
        bus.rd_en           = 1'b1;
        bus.rd_filter_index = fi;
        bus.rd_bias_index   = bi;
        tick();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bus.FB_write = 0; bus.FB_bias_or_filter = 0; bus.FB_index_filter = 0;
        bus.FB_filter = '0; bus.FB_bias = '0;
        bus.rd_en = 0; bus.rd_filter_index = 0; bus.rd_bias_index = 0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                ramp[i][j] = 16'(100 + i * 5 + j);
        tick(); tick();
        chk("rst_fin", bus.FB_finish, 0);
        chk("rst_loaded", bus.filters_loaded, 0);
        chk("rst_rdv", bus.rd_valid, 0);
        chk("rst_rdf", bus.rd_filter, 0);
        reset = 1'b0;
        tick();
        // filter write to slot 3, then read it back the next cycle
        bus.FB_filter = ramp; bus.FB_bias_or_filter = 1; bus.FB_index_filter = 3; bus.FB_write = 1;
        tick();
        chk("cap_fin", bus.FB_finish, 1);
        chk("cap_loaded", bus.filters_loaded, 16'h0008);
        bus.FB_write = 0; bus.rd_en = 1; bus.rd_filter_index = 3;
        tick();
        bus.rd_en = 0;
        chk("rd3", bus.rd_filter, ramp);
        chk("rd3_v", bus.rd_valid, 1);
        chk("rel_fin", bus.FB_finish, 0);
        tick();
        chk("rdv_pulse", bus.rd_valid, 0);
        chk("rd_hold", bus.rd_filter, ramp);
        rd(0, 0);
        chk("unloaded", bus.rd_filter, 0);
        // bias vector
        for (int k = 0; k < 120; k++) bus.FB_bias[k] = 16'(1000 + k);
        wr(0, 0);
        rd(0, 119);
        chk("bias119", bus.rd_bias, 1119);
        rd(0, 120);
        chk("bias120", bus.rd_bias, 0);
        chk("bias120_v", bus.rd_valid, 1);
        rd(0, 0);
        chk("bias0", bus.rd_bias, 1000);
        // FB_write held 10 cycles with data changing during ACK
        bus.FB_filter = fill(16'h22); bus.FB_bias_or_filter = 1; bus.FB_index_filter = 2; bus.FB_write = 1;
        tick();
        chk("hold_fin0", bus.FB_finish, 1);
        bus.FB_filter = fill(16'h33);
        for (int n = 0; n < 9; n++) begin
            tick();
            chk("hold_fin", bus.FB_finish, 1);
        end
        bus.FB_write = 0;
        tick();
        chk("hold_drop", bus.FB_finish, 0);
        rd(2, 0);
        chk("hold_once", bus.rd_filter, fill(16'h22));
        chk("hold_loaded", bus.filters_loaded, 16'h000C);
        // same-edge write and read of slot 5
        bus.FB_filter = fill(16'h7);
        wr(1, 5);
        bus.FB_filter = fill(16'h9); bus.FB_index_filter = 5; bus.FB_write = 1;
        bus.rd_en = 1; bus.rd_filter_index = 5;
        tick();
        chk("same_old", bus.rd_filter, fill(16'h7));
        bus.FB_write = 0;
        tick();
        bus.rd_en = 0;
        chk("same_new", bus.rd_filter, fill(16'h9));
        chk("same_fin", bus.FB_finish, 0);
        // reset while in ACK, write held across release
        bus.FB_filter = fill(16'h55); bus.FB_index_filter = 3; bus.FB_write = 1;
        tick();
        chk("ack_fin", bus.FB_finish, 1);
        reset = 1'b1;
        #1;
        chk("arst_fin", bus.FB_finish, 0);
        chk("arst_loaded", bus.filters_loaded, 0);
        chk("arst_rdf", bus.rd_filter, 0);
        chk("arst_rdb", bus.rd_bias, 0);
        tick();
        reset = 1'b0;
        bus.rd_en = 1; bus.rd_filter_index = 3; bus.rd_bias_index = 119;
        tick();
        bus.rd_en = 0;
        chk("arst_rd3", bus.rd_filter, 0);
        chk("arst_b119", bus.rd_bias, 0);
        chk("held_cap", bus.FB_finish, 1);
        chk("held_loaded", bus.filters_loaded, 16'h0008);
        bus.FB_write = 0;
        tick();
        chk("held_rel", bus.FB_finish, 0);
        rd(3, 0);
        chk("held_data", bus.rd_filter, fill(16'h55));
        rd(5, 0);
        chk("arst_rd5", bus.rd_filter, 0);
        // filter write to index 20
        bus.FB_filter = fill(16'h44);
        wr(1, 20);
        rd(4, 0);
`ifdef FB_RANGE_CHECK_EN
        chk("rng_slot4", bus.rd_filter, 0);
        chk("rng_loaded", bus.filters_loaded, 16'h0008);
        chk("rng_err", bus.wr_err, 1);
        tick();
        chk("rng_sticky", bus.wr_err, 1);
        reset = 1'b1;
        #1;
        chk("rng_clr", bus.wr_err, 0);
        tick();
        reset = 1'b0;
`else
        chk("wrap_slot4", bus.rd_filter, fill(16'h44));
        chk("wrap_loaded", bus.filters_loaded, 16'h0018);
`endif
        rd(20, 0);
        chk("oor_rd", bus.rd_filter, 0);
        chk("oor_v", bus.rd_valid, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
